// File: rtl/slice_cfg_pkg.sv
// Shared constants, sizing helpers and FSM states
// for the slice configuration loader.
package slice_cfg_pkg;

  function automatic int cfg_size(input int s);
    return 2 * (2 ** s) + 1;
  endfunction

  function automatic int mux_lvls(input int n);
    return $clog2(n);
  endfunction

  function automatic int total_bits(input int s, input int n);
    return cfg_size(s) * n + mux_lvls(n) + 2 * n + 1;
  endfunction

  function automatic int num_words(input int s, input int n,
                                   input int w);
    return (total_bits(s, n) + w - 1) / w;
  endfunction

  localparam int DEF_S_XX_BASE  = 4;
  localparam int DEF_NUM_LUTS   = 4;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_TOTAL_BITS =
    total_bits(DEF_S_XX_BASE, DEF_NUM_LUTS);
  localparam int DEF_NUM_WORDS  =
    num_words(DEF_S_XX_BASE, DEF_NUM_LUTS, DEF_WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMB,
    MEM,
    DONE
  } state_e;

endpackage

// File: rtl/slice_config_loader_if.sv
// Valid/ready word stream carrying the
// configuration bitstream into the loader.
interface slice_config_loader_if
  import slice_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/cfg_word_assembler.sv
// Packs accepted words LSB-first into a staging
// register; padding beyond TOTAL_BITS is dropped.
module cfg_word_assembler #(
  parameter int WORD_W     = slice_cfg_pkg::DEF_WORD_W,
  parameter int TOTAL_BITS = slice_cfg_pkg::DEF_TOTAL_BITS,
  parameter int NUM_WORDS  = slice_cfg_pkg::DEF_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [WORD_W-1:0]     data,
  output logic [TOTAL_BITS-1:0] stage_nxt,
  output logic                  last
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  logic [CNT_W-1:0]      cnt_q;
  logic [TOTAL_BITS-1:0] stage_q;

  // stage_nxt already holds the word of this cycle,
  // so the final word can be committed on its edge
  always_comb begin
    stage_nxt = stage_q;
    for (int b = 0; b < TOTAL_BITS; b++) begin
      if (accept && cnt_q == CNT_W'(b / WORD_W)) begin
        stage_nxt[b] = data[b % WORD_W];
      end
    end
  end

  assign last = accept &&
    (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      stage_q <= stage_nxt;
      if (clear) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/slice_config_loader.sv
// Streams a slice configuration in, then issues
// comb/mem commit strobes and a done pulse.
module slice_config_loader
  import slice_cfg_pkg::*;
#(
  parameter int S_XX_BASE = DEF_S_XX_BASE,
  parameter int NUM_LUTS  = DEF_NUM_LUTS,
  parameter int WORD_W    = DEF_WORD_W,
  localparam int CFG_SIZE   = cfg_size(S_XX_BASE),
  localparam int MUX_LVLS   = mux_lvls(NUM_LUTS),
  localparam int TOTAL_BITS = total_bits(S_XX_BASE, NUM_LUTS),
  localparam int NUM_WORDS  =
    num_words(S_XX_BASE, NUM_LUTS, WORD_W)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  slice_config_loader_if.slave cfg,
  output logic busy,
  output logic done,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_out,
  output logic [MUX_LVLS-1:0]   inter_lut_mux_config_out,
  output logic [2*NUM_LUTS-1:0] regs_config_out,
  output logic                  config_use_cc_out,
  output logic                  comb_set,
  output logic                  mem_set
);

  state_e state_q;
  state_e state_d;

  logic                  accept;
  logic                  clear;
  logic                  last;
  logic [TOTAL_BITS-1:0] stage_nxt;

  assign cfg.cfg_ready = (state_q == LOAD) && !abort;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = (state_q != IDLE);

  cfg_word_assembler #(
    .WORD_W     (WORD_W),
    .TOTAL_BITS (TOTAL_BITS),
    .NUM_WORDS  (NUM_WORDS)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept),
    .data      (cfg.cfg_data),
    .stage_nxt (stage_nxt),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    comb_set = 1'b0;
    mem_set  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        unique case (1'b1)
          abort:   state_d = IDLE;
          last:    state_d = COMB;
          default: state_d = LOAD;
        endcase
      end
      COMB: begin
        comb_set = 1'b1;
        state_d  = MEM;
      end
      MEM: begin
        mem_set = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      luts_config_out          <= '0;
      inter_lut_mux_config_out <= '0;
      regs_config_out          <= '0;
      config_use_cc_out        <= 1'b0;
    end else if (last) begin
      {config_use_cc_out,
       regs_config_out,
       inter_lut_mux_config_out,
       luts_config_out} <= stage_nxt;
    end
  end

endmodule

// File: tb/tb_slice_config_loader.sv
// Scoreboard bench for slice_config_loader at
// default parameters (143 bits, 18 words).
module tb_slice_config_loader;

  localparam int W  = 8;
  localparam int NW = 18;

  typedef logic [7:0] wordv_t [NW];

  typedef struct packed {
    logic [131:0] l;
    logic [1:0]   m;
    logic [7:0]   r;
    logic         c;
  } cfg_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [131:0] luts;
  logic [1:0]   mux;
  logic [7:0]   regs;
  logic         cc;
  logic         comb_set;
  logic         mem_set;
  logic         done;
  logic         busy;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   n_strobe = 0;
  cfg_t sb[$];
  cfg_t last_cfg = '0;

  slice_config_loader_if #(.WORD_W(W)) cfg_if ();

  slice_config_loader #(
    .S_XX_BASE (4),
    .NUM_LUTS  (4),
    .WORD_W    (W)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .abort                    (abort),
    .cfg                      (cfg_if),
    .busy                     (busy),
    .done                     (done),
    .luts_config_out          (luts),
    .inter_lut_mux_config_out (mux),
    .regs_config_out          (regs),
    .config_use_cc_out        (cc),
    .comb_set                 (comb_set),
    .mem_set                  (mem_set)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg_if.cfg_valid && cfg_if.cfg_ready)
      hs_cnt <= hs_cnt + 1;
    if (comb_set || mem_set || done)
      n_strobe <= n_strobe + 1;
  end

  function automatic cfg_t model(input wordv_t w);
    logic [NW*W-1:0] v;
    cfg_t c;
    for (int k = 0; k < NW; k++) v[k*W +: W] = w[k];
    c.l = v[131:0];
    c.m = v[133:132];
    c.r = v[141:134];
    c.c = v[142];
    return c;
  endfunction

  task automatic begin_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input wordv_t w, input int n,
                            input bit gaps, input int start_at);
    bit got;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        cfg_if.cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = w[k];
      start = (k == start_at);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (cfg_if.cfg_ready) got = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      if (!got) begin
        n_chk++; n_fail++;
        $display("FAIL handshake_timeout word %0d: ready never seen, required 1", k);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    n_chk++;
    if ({busy, comb_set, mem_set, done, cfg_if.cfg_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: got %b required 00000", tag,
               {busy, comb_set, mem_set, done, cfg_if.cfg_ready});
    end
    n_chk++;
    if ({luts, mux, regs, cc} !== '0) begin
      n_fail++;
      $display("FAIL %s_cfg: got %h required 0", tag,
               {luts, mux, regs, cc});
    end
  endtask

  // Called at #1 after the final handshake edge
  task automatic check_strobes(input string tag, input bit start_in_comb);
    cfg_t exp;
    if (start_in_comb) start = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({comb_set, mem_set, done, busy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL %s_cyc1: got %b required 1001", tag,
               {comb_set, mem_set, done, busy});
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({comb_set, mem_set, done, busy} !== 4'b0101) begin
      n_fail++;
      $display("FAIL %s_cyc2: got %b required 0101", tag,
               {comb_set, mem_set, done, busy});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({comb_set, mem_set, done, busy} !== 4'b0011) begin
      n_fail++;
      $display("FAIL %s_cyc3: got %b required 0011", tag,
               {comb_set, mem_set, done, busy});
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s_sb: done with empty scoreboard, required entry", tag);
      end else begin
        exp = sb.pop_front();
        last_cfg = exp;
        n_chk++;
        if (luts !== exp.l) begin
          n_fail++;
          $display("FAIL %s_luts: got %h required %h", tag, luts, exp.l);
        end
        n_chk++;
        if (mux !== exp.m) begin
          n_fail++;
          $display("FAIL %s_mux: got %b required %b", tag, mux, exp.m);
        end
        n_chk++;
        if (regs !== exp.r) begin
          n_fail++;
          $display("FAIL %s_regs: got %h required %h", tag, regs, exp.r);
        end
        n_chk++;
        if (cc !== exp.c) begin
          n_fail++;
          $display("FAIL %s_cc: got %b required %b", tag, cc, exp.c);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({comb_set, mem_set, done, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s_cyc4: got %b required 0000", tag,
               {comb_set, mem_set, done, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic check_hold(input string tag);
    n_chk++;
    if ({luts, mux, regs, cc} !== last_cfg) begin
      n_fail++;
      $display("FAIL %s_hold: got %h required %h", tag,
               {luts, mux, regs, cc}, last_cfg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    wordv_t w;
    int hs0, c0;
    for (int k = 0; k < NW; k++) w[k] = 8'(k + 1);
    sb.push_back(model(w));
    hs0 = hs_cnt; c0 = cyc;
    begin_load();
    send_words(w, NW, 1'b0, -1);
    n_chk++;
    if (cyc - c0 != NW + 1) begin
      n_fail++;
      $display("FAIL b2b_cycles: got %0d required %0d", cyc - c0, NW + 1);
    end
    check_strobes("b2b", 1'b0);
    n_chk++;
    if ({luts[7:0], mux, regs, cc} !== {8'h01, 2'b01, 8'h48, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_fixed: got %h %b %h %b required 01 01 48 0",
               luts[7:0], mux, regs, cc);
    end
    n_chk++;
    if (hs_cnt - hs0 != NW) begin
      n_fail++;
      $display("FAIL b2b_handshakes: got %0d required %0d", hs_cnt - hs0, NW);
    end
  endtask

  task automatic test_gaps();
    wordv_t w;
    int hs0;
    for (int k = 0; k < NW; k++) w[k] = 8'(k + 1);
    sb.push_back(model(w));
    hs0 = hs_cnt;
    begin_load();
    send_words(w, NW, 1'b1, -1);
    check_strobes("gaps", 1'b0);
    n_chk++;
    if (hs_cnt - hs0 != NW) begin
      n_fail++;
      $display("FAIL gaps_handshakes: got %0d required %0d", hs_cnt - hs0, NW);
    end
  endtask

  task automatic test_abort();
    wordv_t w;
    int hs0, s0;
    for (int k = 0; k < NW; k++) w[k] = 8'hFF;
    hs0 = hs_cnt; s0 = n_strobe;
    begin_load();
    send_words(w, 5, 1'b0, -1);
    abort = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hAA;
    @(negedge clk);
    n_chk++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got %b required 0", cfg_if.cfg_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || hs_cnt - hs0 != 5) begin
      n_fail++;
      $display("FAIL abort_idle: got busy %b hs %0d required 0 5",
               busy, hs_cnt - hs0);
    end
    check_hold("abort");
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (n_strobe != s0) begin
      n_fail++;
      $display("FAIL abort_strobes: got %0d required 0", n_strobe - s0);
    end
    sb.push_back(model(w));
    begin_load();
    send_words(w, NW, 1'b0, -1);
    check_strobes("ones", 1'b0);
    n_chk++;
    if (&{luts, mux, regs, cc} !== 1'b1) begin
      n_fail++;
      $display("FAIL ones_all: got %h required all ones",
               {luts, mux, regs, cc});
    end
    n_chk++;
    if (n_strobe - s0 != 3) begin
      n_fail++;
      $display("FAIL ones_strobes: got %0d required 3", n_strobe - s0);
    end
  endtask

  task automatic test_start_ignored();
    wordv_t w;
    int hs0;
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom_range(0, 255));
    sb.push_back(model(w));
    hs0 = hs_cnt;
    begin_load();
    send_words(w, NW, 1'b0, 7);
    check_strobes("startign", 1'b1);
    n_chk++;
    if (busy !== 1'b0 || hs_cnt - hs0 != NW) begin
      n_fail++;
      $display("FAIL startign_end: got busy %b hs %0d required 0 %0d",
               busy, hs_cnt - hs0, NW);
    end
  endtask

  task automatic test_reset_mid_load();
    wordv_t w;
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom_range(0, 255));
    begin_load();
    send_words(w, 10, 1'b0, -1);
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    check_idle_zero("rstmid");
    @(posedge clk); #1;
    for (int k = 0; k < NW; k++) w[k] = 8'($urandom_range(0, 255));
    sb.push_back(model(w));
    begin_load();
    send_words(w, NW, 1'b0, -1);
    check_strobes("afterrst", 1'b0);
  endtask

  task automatic test_hold_partial();
    wordv_t w;
    for (int k = 0; k < NW; k++) w[k] = 8'h5A;
    begin_load();
    send_words(w, NW - 1, 1'b0, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy: got %b required 1", busy);
    end
    check_hold("partial");
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_start_ignored();
    test_reset_mid_load();
    test_hold_partial();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slice_config_loader.md
SLICE_CONFIG_LOADER -- requirements
Module: slice_config_loader

Interface
REQ-001 Parameter S_XX_BASE, default 4: LUT base input count of the target slice.
REQ-002 Parameter NUM_LUTS, default 4: LUTs per slice, a power of 2.
REQ-003 Parameter WORD_W, default 8: width of the configuration input word.
REQ-004 Derived constants SHALL be:
- CFG_SIZE = 2*(2**S_XX_BASE)+1
- MUX_LVLS = clog2(NUM_LUTS)
- TOTAL_BITS = CFG_SIZE*NUM_LUTS + MUX_LVLS + 2*NUM_LUTS + 1 (143 at defaults)
- NUM_WORDS = ceil(TOTAL_BITS/WORD_W) (18 at defaults)
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request a new configuration load.
REQ-008 abort  input  1  cancel a load in progress.
REQ-009 cfg_valid  input  1  cfg_data holds a word.
REQ-010 cfg_data  input  WORD_W  configuration word, LSB-first bit stream.
REQ-011 cfg_ready  output  1  loader accepts a word this cycle.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when a load completes.
REQ-014 luts_config_out  output  CFG_SIZE*NUM_LUTS  to slice luts_config_in.
REQ-015 inter_lut_mux_config_out  output  MUX_LVLS  to slice inter_lut_mux_config.
REQ-016 regs_config_out  output  2*NUM_LUTS  to slice regs_config_in.
REQ-017 config_use_cc_out  output  1  to slice config_use_cc.
REQ-018 comb_set  output  1  one-cycle combinational-config commit strobe to the slice.
REQ-019 mem_set  output  1  one-cycle register-init strobe to the slice.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, COMB, MEM and DONE.
REQ-021 In IDLE, start=1 SHALL move the FSM to LOAD and clear the word counter; start SHALL be ignored in every other state.
REQ-022 cfg_ready SHALL equal (state==LOAD && !abort).
REQ-023 A word SHALL be accepted only on a cycle with cfg_valid && cfg_ready.
REQ-024 Word k SHALL be written to staging bits [k*WORD_W +: WORD_W]; the counter SHALL increment by 1 per accepted word.
REQ-025 Staging bits at or above TOTAL_BITS (last-word padding) SHALL be discarded.
REQ-026 Acceptance of word NUM_WORDS-1 SHALL move the FSM to COMB.
REQ-027 On that same edge, all four config outputs SHALL load from staging, packed LSB-first in this order:
- luts_config_out
- inter_lut_mux_config_out
- regs_config_out
- config_use_cc_out
REQ-028 The config outputs SHALL change only on that edge and SHALL otherwise hold, including through abort and while a subsequent load is in progress.
REQ-029 COMB SHALL assert comb_set for exactly one cycle and then go to MEM.
REQ-030 MEM SHALL assert mem_set for exactly one cycle and then go to DONE.
REQ-031 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-032 comb_set, mem_set and done SHALL therefore assert on cycles +1, +2 and +3 after the final handshake edge, each mutually exclusive.
REQ-033 abort=1 in LOAD SHALL return the FSM to IDLE on the next edge, with no word accepted that cycle and no strobes issued.
REQ-034 abort SHALL have no effect outside LOAD.
REQ-035 A cfg_valid gap of any length SHALL stall the counter without loss of data.

Reset
REQ-036 While rst_n=0 at a rising edge, all of the following SHALL be 0 / IDLE after that edge:
- state=IDLE, counter and staging
- all config outputs
- comb_set, mem_set, done, busy and cfg_ready
REQ-037 Reset SHALL take precedence over start, abort and handshakes, including mid-LOAD and mid-strobe.

Structure
REQ-038 The derived constants and the FSM state enum SHALL live in a shared package, slice_cfg_pkg.
REQ-039 The word-assembly register and counter SHALL form one sub-module, cfg_word_assembler; the FSM and output registers SHALL stay in the top module.

Verification
REQ-040 Reset, then start, then words 0x01..0x12 back-to-back SHALL give:
- luts_config_out[7:0]=0x01
- inter_lut_mux_config_out=2'b01
- regs_config_out=0x48
- config_use_cc_out=0
- comb_set, mem_set, done on cycles +1, +2, +3 after the last handshake
REQ-041 The same load with cfg_valid low every other cycle SHALL give identical outputs, with exactly 18 handshakes counted.
REQ-042 abort after 5 words, then a full load of 18 words of 0xFF, SHALL give:
- no strobes from the aborted load
- all config outputs all-ones after the full load (padding bit 143 discarded)
REQ-043 start pulsed during LOAD and during COMB SHALL leave the counter, state sequence and strobe timing unchanged.
REQ-044 rst_n=0 after 10 words SHALL return the FSM to IDLE with outputs zero; a following full load SHALL complete normally.
REQ-045 After a completed load, starting a second load and sending 17 words SHALL leave the config outputs holding the first load's values.
